// File: rtl/keyed_lock_pkg.sv
// Shared constants and helpers for the keyed state register.
// Lockout mode encodings plus a clog2 that never yields a zero-width field.
package keyed_lock_pkg;

  localparam int LOCK_NONE   = 0;
  localparam int LOCK_STICKY = 1;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/keyed_state_reg_if.sv
// Bundle between the locked FSM and its keyed present-state register.
// master = FSM/key source side, slave = the register itself.
interface keyed_state_reg_if #(
  parameter int STATE_W = 4,
  parameter int KEY_W   = 10,
  parameter int WIN_W   = 2,
  parameter int MISS_W  = 8
);
  logic               en;
  logic [KEY_W-1:0]   key_in;
  logic [STATE_W-1:0] nx_state;
  logic [STATE_W-1:0] pr_state;
  logic [WIN_W-1:0]   win_idx;
  logic               key_ok;
  logic               locked;
  logic [MISS_W-1:0]  miss_cnt;

  modport master (
    output en, key_in, nx_state,
    input  pr_state, win_idx, key_ok, locked, miss_cnt
  );

  modport slave (
    input  en, key_in, nx_state,
    output pr_state, win_idx, key_ok, locked, miss_cnt
  );
endinterface

// File: rtl/key_window_sched.sv
// Free-running key schedule: period counter plus registered window index.
// Updates on the falling edge, holds while en=0; window index kept without a divider.
module key_window_sched
  import keyed_lock_pkg::*;
#(
  parameter int NUM_WIN = 3,
  parameter int WIN_LEN = 6,
  localparam int WIN_W  = clog2_min1(NUM_WIN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_en,
  output logic [WIN_W-1:0] o_win_idx
);
  localparam int PERIOD = NUM_WIN * WIN_LEN;
  localparam int CNT_W  = clog2_min1(PERIOD);
  localparam int POS_W  = clog2_min1(WIN_LEN);

  logic [CNT_W-1:0] r_cnt;
  logic [POS_W-1:0] r_pos;
  logic [WIN_W-1:0] r_win;
  logic             w_wrap;
  logic             w_win_end;

  assign w_wrap    = (r_cnt == CNT_W'(PERIOD - 1));
  assign w_win_end = (r_pos == POS_W'(WIN_LEN - 1));

  // r_pos is the offset inside the current window; it drives the window step.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_pos <= '0;
      r_win <= '0;
    end else if (i_en) begin
      if (w_wrap) begin
        r_cnt <= '0;
        r_pos <= '0;
        r_win <= '0;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
        if (w_win_end) begin
          r_pos <= '0;
          r_win <= r_win + WIN_W'(1);
        end else begin
          r_pos <= r_pos + POS_W'(1);
        end
      end
    end
  end

  assign o_win_idx = r_win;
endmodule

// File: rtl/keyed_state_reg.sv
// Key-scheduled present-state register: loads nx_state on a key match, else the window's trap.
// One falling edge of latency; en=0 freezes everything, optional sticky lockout and miss count.
module keyed_state_reg
  import keyed_lock_pkg::*;
#(
  parameter int                         STATE_W     = 4,
  parameter int                         KEY_W       = 10,
  parameter int                         NUM_WIN     = 3,
  parameter int                         WIN_LEN     = 6,
  parameter logic [NUM_WIN*KEY_W-1:0]   KEYS        = '0,
  parameter logic [NUM_WIN*STATE_W-1:0] TRAPS       = '0,
  parameter logic [STATE_W-1:0]         RESET_STATE = STATE_W'(1),
  parameter int                         LOCKOUT     = LOCK_NONE,
  parameter int                         MISS_W      = 8
) (
  input logic              clk,
  input logic              rst_n,
  keyed_state_reg_if.slave bus
);
  localparam int WIN_W = clog2_min1(NUM_WIN);

  logic [WIN_W-1:0]   w_win_idx;
  logic [KEY_W-1:0]   w_key_exp;
  logic [STATE_W-1:0] w_trap;
  logic               w_key_ok;
  logic [STATE_W-1:0] r_pr_state;
  logic               r_locked;
  logic [MISS_W-1:0]  r_miss_cnt;

  key_window_sched #(
    .NUM_WIN (NUM_WIN),
    .WIN_LEN (WIN_LEN)
  ) u_sched (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_en      (bus.en),
    .o_win_idx (w_win_idx)
  );

  assign w_key_exp = KEYS[w_win_idx*KEY_W +: KEY_W];
  assign w_trap    = TRAPS[w_win_idx*STATE_W +: STATE_W];
  assign w_key_ok  = (bus.key_in == w_key_exp) && !r_locked;

  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pr_state <= RESET_STATE;
      r_locked   <= 1'b0;
      r_miss_cnt <= '0;
    end else if (bus.en) begin
      if (w_key_ok) begin
        r_pr_state <= bus.nx_state;
      end else begin
        r_pr_state <= w_trap;
        if (r_miss_cnt != {MISS_W{1'b1}}) begin
          r_miss_cnt <= r_miss_cnt + MISS_W'(1);
        end
        if (LOCKOUT == LOCK_STICKY) begin
          r_locked <= 1'b1;
        end
      end
    end
  end

  assign bus.pr_state = r_pr_state;
  assign bus.win_idx  = w_win_idx;
  assign bus.key_ok   = w_key_ok;
  assign bus.locked   = r_locked;
  assign bus.miss_cnt = r_miss_cnt;
endmodule

// File: tb/tb_keyed_state_reg.sv
// Randomized + directed bench: two instances (no lockout / MISS_W=8, sticky lockout / MISS_W=2)
// share stimulus and are checked against a per-edge behavioural model of the key schedule.
module tb_keyed_state_reg;
  import keyed_lock_pkg::*;

  localparam int P  = 18;
  localparam int WL = 6;

  logic clk;
  logic rst_n;

  keyed_state_reg_if #(.STATE_W(4), .KEY_W(10), .WIN_W(2), .MISS_W(8)) ifa ();
  keyed_state_reg_if #(.STATE_W(4), .KEY_W(10), .WIN_W(2), .MISS_W(2)) ifb ();

  keyed_state_reg #(
    .KEYS({10'd860, 10'd1002, 10'd859}), .TRAPS({4'd9, 4'd7, 4'd5}),
    .RESET_STATE(4'd1), .LOCKOUT(LOCK_NONE), .MISS_W(8)
  ) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));

  keyed_state_reg #(
    .KEYS({10'd860, 10'd1002, 10'd859}), .TRAPS({4'd9, 4'd7, 4'd5}),
    .RESET_STATE(4'd1), .LOCKOUT(LOCK_STICKY), .MISS_W(2)
  ) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  logic [9:0] key_tab [3] = '{10'd859, 10'd1002, 10'd860};
  int         trap_tab[3] = '{5, 7, 9};
  int         lock_cfg[2] = '{0, 1};
  int         miss_max[2] = '{255, 3};

  int m_edges;
  int m_pr[2];
  int m_miss[2];
  int m_locked[2];

  int n_total = 0;
  int n_bad   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int cur_win();
    return (m_edges % P) / WL;
  endfunction

  task automatic check_all(input string ph);
    int g_pr[2], g_miss[2], g_lk[2], g_win[2];
    g_pr[0] = int'(ifa.pr_state);  g_pr[1] = int'(ifb.pr_state);
    g_miss[0] = int'(ifa.miss_cnt); g_miss[1] = int'(ifb.miss_cnt);
    g_lk[0] = int'(ifa.locked);    g_lk[1] = int'(ifb.locked);
    g_win[0] = int'(ifa.win_idx);  g_win[1] = int'(ifb.win_idx);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("%s_pr%0d", ph, d), g_pr[d], m_pr[d]);
      check($sformatf("%s_miss%0d", ph, d), g_miss[d], m_miss[d]);
      check($sformatf("%s_lock%0d", ph, d), g_lk[d], m_locked[d]);
      check($sformatf("%s_win%0d", ph, d), g_win[d], cur_win());
    end
  endtask

  task automatic drive(input logic e, input logic [9:0] k, input logic [3:0] nx);
    ifa.en = e; ifa.key_in = k; ifa.nx_state = nx;
    ifb.en = e; ifb.key_in = k; ifb.nx_state = nx;
  endtask

  // Asserted between edges so the asynchronous return is observed before any clock.
  task automatic do_reset();
    @(posedge clk);
    #2 rst_n = 1'b0;
    m_edges = 0;
    for (int d = 0; d < 2; d++) begin
      m_pr[d] = 1; m_miss[d] = 0; m_locked[d] = 0;
    end
    #1;
    check_all("rst");
    check("rst_keyok0", int'(ifa.key_ok), int'(ifa.key_in == key_tab[0]));
    check("rst_keyok1", int'(ifb.key_ok), int'(ifb.key_in == key_tab[0]));
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic cycle(input logic e, input logic [9:0] k, input logic [3:0] nx);
    int w;
    int ok[2];
    @(posedge clk);
    #1 drive(e, k, nx);
    #1;
    w = cur_win();
    for (int d = 0; d < 2; d++) ok[d] = int'((k == key_tab[w]) && (m_locked[d] == 0));
    check("keyok0", int'(ifa.key_ok), ok[0]);
    check("keyok1", int'(ifb.key_ok), ok[1]);
    if (e) begin
      for (int d = 0; d < 2; d++) begin
        if (ok[d] != 0) begin
          m_pr[d] = int'(nx);
        end else begin
          m_pr[d] = trap_tab[w];
          if (m_miss[d] < miss_max[d]) m_miss[d]++;
          if (lock_cfg[d] != 0) m_locked[d] = 1;
        end
      end
      m_edges++;
    end
    @(negedge clk);
    #1 check_all("edge");
  endtask

  initial begin
    rst_n = 1'b1;
    drive(1'b0, 10'd859, 4'd0);
    m_edges = 0;

    do_reset();
    // Correct key in every window; pr_state follows nx_state.
    for (int c = 0; c < 36; c++) cycle(1'b1, key_tab[cur_win()], 4'(c % 16));
    check("follow_miss", int'(ifa.miss_cnt), 0);

    // Window-0 key held: windows 1/2 trap.
    do_reset();
    for (int c = 0; c < 18; c++) cycle(1'b1, 10'd859, 4'(c));
    check("hold859_miss", int'(ifa.miss_cnt), 12);
    check("hold859_sat", int'(ifb.miss_cnt), 3);

    // Single wrong key at cnt=3 locks instance b.
    do_reset();
    for (int c = 0; c < 3; c++) cycle(1'b1, key_tab[cur_win()], 4'(c + 2));
    cycle(1'b1, 10'd0, 4'd14);
    check("lock_trap", int'(ifb.pr_state), 5);
    check("lock_flag", int'(ifb.locked), 1);
    for (int c = 0; c < 15; c++) cycle(1'b1, key_tab[cur_win()], 4'(c));
    do_reset();
    check("unlock", int'(ifb.locked), 0);

    // Freeze at cnt=5, then the held edge still uses window 0.
    for (int c = 0; c < 5; c++) cycle(1'b1, key_tab[cur_win()], 4'(c + 3));
    for (int c = 0; c < 4; c++) cycle(1'b0, 10'($urandom), 4'($urandom));
    cycle(1'b1, key_tab[0], 4'd11);
    check("thaw_pr", int'(ifa.pr_state), 11);

    // All keys wrong: b saturates at 3.
    do_reset();
    for (int c = 0; c < 10; c++) cycle(1'b1, 10'd0, 4'($urandom));
    check("sat_a", int'(ifa.miss_cnt), 10);
    check("sat_b", int'(ifb.miss_cnt), 3);

    // Reach cnt=8 (window 1) and reset asynchronously.
    do_reset();
    for (int c = 0; c < 8; c++) cycle(1'b1, key_tab[cur_win()], 4'(c));
    check("mid_win", int'(ifa.win_idx), 1);
    do_reset();

    // Randomized mix of enables, keys and occasional resets.
    for (int c = 0; c < 400; c++) begin
      logic       e;
      logic [9:0] k;
      e = ($urandom_range(0, 3) != 0);
      k = ($urandom_range(0, 4) != 0) ? key_tab[cur_win()] : 10'($urandom);
      cycle(e, k, 4'($urandom));
      if ($urandom_range(0, 99) == 0) do_reset();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
